// File: rtl/memset_pkg.sv
// -----------------------------------------------------------------------------
// memset_pkg
//
// Shared definitions for the memset stream sequencer slice.
//
// Contents:
//   DATA_WIDTH_DEF   default beat width in bits (multiple of 8)
//   COUNT_WIDTH_DEF  default width of the beat-count CSR and job counters
//   BUF_DEPTH_DEF    output buffer depth; the buffer is built for exactly 2
//   state_e          job sequencer state encoding
// -----------------------------------------------------------------------------
package memset_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 512;
    localparam int unsigned COUNT_WIDTH_DEF = 32;
    localparam int unsigned BUF_DEPTH_DEF   = 2;

    // IDLE  : waiting for a start pulse
    // RUN   : accepting input beats until N have been taken
    // DRAIN : input closed, waiting for the buffer to empty downstream
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/memset_skid_fifo.sv
// -----------------------------------------------------------------------------
// memset_skid_fifo
//
// Two-entry register FIFO sitting between the fill datapath and the write
// streamer. Push and pop may occur in the same cycle; occupancy is tracked
// with a small counter and the entries are addressed by 1-bit pointers.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset; empties the FIFO and zeroes data
//   push_i   write data_i into the tail entry (ignored when full)
//   data_i   beat to store
//   pop_i    drop the head entry (ignored when empty)
//   full_o   both entries occupied
//   empty_o  no entries occupied
//   data_o   head entry contents
// -----------------------------------------------------------------------------
module memset_skid_fifo
    import memset_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_WIDTH_DEF,
    parameter int unsigned Depth     = BUF_DEPTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DataWidth-1:0] data_o
);

    logic [DataWidth-1:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 wr_ptr_d;
    logic                 rd_ptr_q;
    logic                 rd_ptr_d;
    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (count_q == 2'(Depth));
    assign empty_o = (count_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    // Guarding here keeps the occupancy counter consistent even if a caller
    // misbehaves; the sequencer never requests either illegal operation.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Occupancy never exceeds the two physical entries.
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= 2'd2);

endmodule

// File: rtl/memset_stream_sequencer.sv
// -----------------------------------------------------------------------------
// memset_stream_sequencer
//
// Bounded-length stream stage behind the memset fill datapath. A start pulse
// with a non-zero beat count N opens a job: exactly N upstream beats are
// accepted, buffered in a 2-entry FIFO and forwarded unaltered downstream.
// The job closes when the N-th beat leaves the buffer, with busy dropping and
// a one-cycle done pulse on the same cycle. A start with N=0 completes
// immediately with a done pulse and no data movement.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high on that interface. Upstream ready is a function of registered
// state only (FSM state, accept count, FIFO fullness), so there is no
// combinational path from ext_data_o_ready to ext_data_i_ready.
//
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   ext_data_i_valid/_ready/_bits    beat stream from the fill datapath
//   ext_data_o_valid/_ready/_bits    beat stream to the write streamer
//   ext_csr_i_0                      beat count N sampled on start
//   ext_start_i                      job start pulse (ignored while busy)
//   ext_busy_o                       job in progress
//   ext_done_o                       one-cycle completion pulse
//   ext_beats_sent_o                 output transfers in current/last job
// -----------------------------------------------------------------------------
module memset_stream_sequencer
    import memset_pkg::*;
#(
    parameter int unsigned DataWidth  = DATA_WIDTH_DEF,
    parameter int unsigned CountWidth = COUNT_WIDTH_DEF,
    parameter int unsigned BufDepth   = BUF_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ext_data_i_valid,
    output logic                  ext_data_i_ready,
    input  logic [DataWidth-1:0]  ext_data_i_bits,
    output logic                  ext_data_o_valid,
    input  logic                  ext_data_o_ready,
    output logic [DataWidth-1:0]  ext_data_o_bits,
    input  logic [CountWidth-1:0] ext_csr_i_0,
    input  logic                  ext_start_i,
    output logic                  ext_busy_o,
    output logic                  ext_done_o,
    output logic [CountWidth-1:0] ext_beats_sent_o
);

    localparam logic [CountWidth-1:0] CntOne = CountWidth'(1);

    state_e                state_q;
    state_e                state_d;
    logic [CountWidth-1:0] n_q;
    logic [CountWidth-1:0] n_d;
    logic [CountWidth-1:0] accepted_q;
    logic [CountWidth-1:0] accepted_d;
    logic [CountWidth-1:0] sent_q;
    logic [CountWidth-1:0] sent_d;
    logic                  done_q;
    logic                  done_d;

    logic                  buf_full;
    logic                  buf_empty;
    logic                  in_fire;
    logic                  out_fire;
    logic [CountWidth-1:0] accepted_inc;
    logic [CountWidth-1:0] sent_inc;

    // -------------------------------------------------------------------------
    // Output buffer
    // -------------------------------------------------------------------------
    memset_skid_fifo #(
        .DataWidth (DataWidth),
        .Depth     (BufDepth)
    ) u_buf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (in_fire),
        .data_i  (ext_data_i_bits),
        .pop_i   (out_fire),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .data_o  (ext_data_o_bits)
    );

    // -------------------------------------------------------------------------
    // Handshake qualification
    // -------------------------------------------------------------------------
    // Outside RUN the input stays closed so stray upstream beats are left
    // waiting rather than swallowed.
    assign ext_data_i_ready = (state_q == RUN) && (accepted_q < n_q) && !buf_full;
    assign ext_data_o_valid = !buf_empty;

    assign in_fire  = ext_data_i_valid && ext_data_i_ready;
    assign out_fire = ext_data_o_valid && ext_data_o_ready;

    assign accepted_inc = accepted_q + CntOne;
    assign sent_inc     = sent_q + CntOne;

    // -------------------------------------------------------------------------
    // Job sequencer: next-state and counter updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        accepted_d = accepted_q;
        sent_d     = sent_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ext_start_i) begin
                    sent_d = '0;
                    if (ext_csr_i_0 != '0) begin
                        n_d        = ext_csr_i_0;
                        accepted_d = '0;
                        state_d    = RUN;
                    end else begin
                        // Zero-length job: nothing to move, complete at once.
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (in_fire) begin
                    accepted_d = accepted_inc;
                    if (accepted_inc == n_q) begin
                        state_d = DRAIN;
                    end
                end
                // Pops during RUN can never be the last one: at most
                // accepted_q < N beats have entered the buffer so far.
                if (out_fire) begin
                    sent_d = sent_inc;
                end
            end

            DRAIN: begin
                if (out_fire) begin
                    sent_d = sent_inc;
                    if (sent_inc == n_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            accepted_q <= '0;
            sent_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            accepted_q <= accepted_d;
            sent_q     <= sent_d;
            done_q     <= done_d;
        end
    end

    // busy and done both derive from registers updated on the same edge, so
    // the done pulse coincides with busy falling.
    assign ext_busy_o       = (state_q != IDLE);
    assign ext_done_o       = done_q;
    assign ext_beats_sent_o = sent_q;

    // -------------------------------------------------------------------------
    // Embedded properties
    // -------------------------------------------------------------------------
    // Every beat the buffer emits was accepted within this job.
    a_sent_le_accepted: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != IDLE) |-> (sent_q <= accepted_q));

    // The accept counter never runs past the latched job length.
    a_accepted_le_n: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != IDLE) |-> (accepted_q <= n_q));

    // Upstream is never offered ready while the buffer is full.
    a_no_ready_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        buf_full |-> !ext_data_i_ready);

endmodule

// File: tb/tb_memset_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_memset_stream_sequencer
//
// Scenario tasks drive jobs into memset_stream_sequencer and compare what came
// out against a reference built from the job rules: with upstream presenting
// beats in order and holding each one until taken, a job of length N forwards
// exactly the first N offered beats, in order, and completes with one done
// pulse while beats_sent reads N.
// -----------------------------------------------------------------------------
module tb_memset_stream_sequencer;

    localparam int DW = 512;
    localparam int CW = 32;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ext_data_i_valid = 1'b0;
    logic          ext_data_i_ready;
    logic [DW-1:0] ext_data_i_bits = '0;
    logic          ext_data_o_valid;
    logic          ext_data_o_ready = 1'b0;
    logic [DW-1:0] ext_data_o_bits;
    logic [CW-1:0] ext_csr_i_0 = '0;
    logic          ext_start_i = 1'b0;
    logic          ext_busy_o;
    logic          ext_done_o;
    logic [CW-1:0] ext_beats_sent_o;

    always #5 clk = ~clk;

    memset_stream_sequencer #(
        .DataWidth  (DW),
        .CountWidth (CW),
        .BufDepth   (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ext_data_i_valid (ext_data_i_valid),
        .ext_data_i_ready (ext_data_i_ready),
        .ext_data_i_bits  (ext_data_i_bits),
        .ext_data_o_valid (ext_data_o_valid),
        .ext_data_o_ready (ext_data_o_ready),
        .ext_data_o_bits  (ext_data_o_bits),
        .ext_csr_i_0      (ext_csr_i_0),
        .ext_start_i      (ext_start_i),
        .ext_busy_o       (ext_busy_o),
        .ext_done_o       (ext_done_o),
        .ext_beats_sent_o (ext_beats_sent_o)
    );

    // -------------------------------------------------------------------------
    // Bench state: source queue, observations, reference model
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] src_q[$];      // beats still waiting upstream
    logic [DW-1:0] offered_q[$];  // every beat offered in the current scenario
    logic [DW-1:0] out_q[$];      // beats observed leaving the DUT
    logic [DW-1:0] exp_q[$];      // reference: what should have left the DUT
    logic [CW-1:0] sent_at_done_q[$];

    int   cyc = 0;
    int   job_n;          // length of the job the model believes is open
    int   n_acc;          // input transfers in the current job
    int   n_sent;         // output transfers in the current job
    int   done_cnt;
    int   busy_cnt;
    int   first_in_cyc;
    int   first_out_cyc;
    int   last_out_cyc;
    int   ready_viol;     // ready seen where the job rules forbid it
    int   full_stall;     // valid held off because two beats were in flight
    int   done_with_busy;
    int   in_mode  = 0;   // 0: valid whenever a beat exists, 1: random gaps
    int   out_mode = 0;   // 0: always ready, 1: toggle, 2: random, 3: never
    logic out_tog  = 1'b0;

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < DW / 32; i++) begin
            b[i*32 +: 32] = $urandom;
        end
        return b;
    endfunction

    task automatic clear_model(input int n);
        out_q.delete();
        sent_at_done_q.delete();
        job_n          = n;
        n_acc          = 0;
        n_sent         = 0;
        done_cnt       = 0;
        busy_cnt       = 0;
        first_in_cyc   = -1;
        first_out_cyc  = -1;
        last_out_cyc   = -1;
        ready_viol     = 0;
        full_stall     = 0;
        done_with_busy = 0;
    endtask

    // Reference model: the first n offered beats, in offer order.
    task automatic build_expected(input int n);
        exp_q.delete();
        for (int i = 0; i < n && i < offered_q.size(); i++) begin
            exp_q.push_back(offered_q[i]);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive();
        ext_data_i_valid = (src_q.size() > 0) && (in_mode == 0 || $urandom_range(0, 3) != 0);
        ext_data_i_bits  = (src_q.size() > 0) ? src_q[0] : '0;
        case (out_mode)
            0: ext_data_o_ready = 1'b1;
            1: begin
                out_tog          = !out_tog;
                ext_data_o_ready = out_tog;
            end
            2: ext_data_o_ready = ($urandom_range(0, 2) != 0);
            default: ext_data_o_ready = 1'b0;
        endcase
    endtask

    task automatic load_src(input int count);
        src_q.delete();
        offered_q.delete();
        for (int i = 0; i < count; i++) begin
            logic [DW-1:0] b;
            b = rand_beat();
            src_q.push_back(b);
            offered_q.push_back(b);
        end
        drive();
    endtask

    // One clock: observe at the falling edge, then advance past the rising
    // edge and re-drive inputs 1 time unit later.
    task automatic tick();
        logic in_hs;
        logic out_hs;
        @(negedge clk);
        in_hs  = ext_data_i_valid && ext_data_i_ready;
        out_hs = ext_data_o_valid && ext_data_o_ready;
        if (ext_data_i_ready && (!ext_busy_o || (n_acc - n_sent) >= 2 || n_acc >= job_n)) begin
            ready_viol++;
        end
        if (ext_data_i_valid && !ext_data_i_ready && ext_busy_o && (n_acc - n_sent) == 2) begin
            full_stall++;
        end
        if (ext_busy_o) busy_cnt++;
        if (ext_done_o) begin
            done_cnt++;
            sent_at_done_q.push_back(ext_beats_sent_o);
            if (ext_busy_o) done_with_busy++;
        end
        if (in_hs) begin
            if (n_acc == 0) first_in_cyc = cyc;
            n_acc++;
        end
        if (out_hs) begin
            out_q.push_back(ext_data_o_bits);
            if (n_sent == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            n_sent++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (in_hs) void'(src_q.pop_front());
        drive();
    endtask

    task automatic start_job(input int n);
        ext_csr_i_0 = CW'(n);
        ext_start_i = 1'b1;
        tick();
        ext_start_i = 1'b0;
        ext_csr_i_0 = CW'($urandom);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic idle_src();
        src_q.delete();
        drive();
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        clear_model(0);
        in_mode  = 0;
        out_mode = 0;
        rst_n    = 1'b0;
        load_src(2);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (ext_busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", ext_busy_o);
        else n_pass++;
        n_checks++;
        if (ext_done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", ext_done_o);
        else n_pass++;
        n_checks++;
        if (ext_data_o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b want 0", ext_data_o_valid);
        else n_pass++;
        n_checks++;
        if (ext_data_i_ready !== 1'b0) $display("FAIL reset_i_ready: got %b want 0", ext_data_i_ready);
        else n_pass++;
        n_checks++;
        if (ext_beats_sent_o !== '0) $display("FAIL reset_beats_sent: got %0d want 0", ext_beats_sent_o);
        else n_pass++;
        n_checks++;
        if (ext_data_o_bits !== '0) $display("FAIL reset_o_bits: got %h want 0", ext_data_o_bits);
        else n_pass++;
        n_checks++;
        if (n_acc !== 0) $display("FAIL reset_idle_accept: got %0d accepted want 0", n_acc);
        else n_pass++;
        idle_src();
    endtask

    task automatic test_n4_full_rate();
        int bad;
        clear_model(4);
        in_mode  = 0;
        out_mode = 0;
        load_src(6);
        build_expected(4);
        start_job(4);
        wait_done(1, 40);
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (out_q.size() != exp_q.size() || bad != 0)
            $display("FAIL n4_data: got %0d beats (%0d wrong) want %0d", out_q.size(), bad, exp_q.size());
        else n_pass++;
        n_checks++;
        if (busy_cnt != 5) $display("FAIL n4_busy_cycles: got %0d want 5", busy_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL n4_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (ext_beats_sent_o !== CW'(4)) $display("FAIL n4_beats_sent: got %0d want 4", ext_beats_sent_o);
        else n_pass++;
        n_checks++;
        if (src_q.size() != 2) $display("FAIL n4_fifth_beat: got %0d left upstream want 2", src_q.size());
        else n_pass++;
        n_checks++;
        if (first_out_cyc - first_in_cyc != 1)
            $display("FAIL n4_latency: got %0d cycles want 1", first_out_cyc - first_in_cyc);
        else n_pass++;
        n_checks++;
        if (last_out_cyc - first_out_cyc != 3)
            $display("FAIL n4_throughput: got span %0d want 3", last_out_cyc - first_out_cyc);
        else n_pass++;
        n_checks++;
        if (ready_viol != 0) $display("FAIL n4_ready_rule: got %0d violations want 0", ready_viol);
        else n_pass++;
        idle_src();
    endtask

    task automatic test_n8_toggle();
        int bad;
        clear_model(8);
        in_mode  = 0;
        out_mode = 1;
        load_src(10);
        build_expected(8);
        start_job(8);
        wait_done(1, 80);
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (out_q.size() != exp_q.size() || bad != 0)
            $display("FAIL n8_data: got %0d beats (%0d wrong) want %0d", out_q.size(), bad, exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL n8_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (sent_at_done_q.size() != 1 || sent_at_done_q[0] !== CW'(8))
            $display("FAIL n8_sent_at_done: got %0d entries first %0d want 8",
                     sent_at_done_q.size(), (sent_at_done_q.size() > 0) ? sent_at_done_q[0] : '0);
        else n_pass++;
        n_checks++;
        if (full_stall == 0) $display("FAIL n8_full_stall: got %0d stalls want >0", full_stall);
        else n_pass++;
        n_checks++;
        if (ready_viol != 0) $display("FAIL n8_ready_rule: got %0d violations want 0", ready_viol);
        else n_pass++;
        idle_src();
    endtask

    task automatic test_zero_length();
        clear_model(0);
        in_mode  = 0;
        out_mode = 0;
        load_src(2);
        start_job(0);
        n_checks++;
        if (ext_done_o !== 1'b1) $display("FAIL zero_done_pulse: got %b want 1", ext_done_o);
        else n_pass++;
        n_checks++;
        if (ext_busy_o !== 1'b0) $display("FAIL zero_busy: got %b want 0", ext_busy_o);
        else n_pass++;
        n_checks++;
        if (ext_beats_sent_o !== '0) $display("FAIL zero_beats_sent: got %0d want 0", ext_beats_sent_o);
        else n_pass++;
        tick();
        n_checks++;
        if (ext_done_o !== 1'b0) $display("FAIL zero_done_width: got %b want 0", ext_done_o);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (n_acc != 0 || busy_cnt != 0 || ready_viol != 0)
            $display("FAIL zero_quiet: got acc %0d busy %0d viol %0d want 0 0 0", n_acc, busy_cnt, ready_viol);
        else n_pass++;
        idle_src();
    endtask

    task automatic test_restart_ignored();
        int bad;
        clear_model(3);
        in_mode  = 1;
        out_mode = 2;
        load_src(10);
        build_expected(3);
        start_job(3);
        tick();
        ext_csr_i_0 = CW'(100);
        ext_start_i = 1'b1;
        tick();
        ext_start_i = 1'b0;
        wait_done(1, 200);
        repeat (5) tick();
        bad = 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (out_q.size() != exp_q.size() || bad != 0)
            $display("FAIL restart_data: got %0d beats (%0d wrong) want %0d", out_q.size(), bad, exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL restart_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (ext_beats_sent_o !== CW'(3)) $display("FAIL restart_beats_sent: got %0d want 3", ext_beats_sent_o);
        else n_pass++;
        n_checks++;
        if (n_acc != 3) $display("FAIL restart_accepted: got %0d want 3", n_acc);
        else n_pass++;
        n_checks++;
        if (ready_viol != 0) $display("FAIL restart_ready_rule: got %0d violations want 0", ready_viol);
        else n_pass++;
        idle_src();
    endtask

    task automatic test_reset_mid_job();
        int bad;
        int k;
        clear_model(4);
        in_mode  = 0;
        out_mode = 3;
        load_src(6);
        start_job(4);
        k = 0;
        while ((n_acc - n_sent) < 2 && k < 20) begin
            tick();
            k++;
        end
        tick();
        n_checks++;
        if (ext_data_o_valid !== 1'b1 || (n_acc - n_sent) != 2)
            $display("FAIL rst_mid_setup: got valid %b occupancy %0d want 1 2", ext_data_o_valid, n_acc - n_sent);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ext_data_o_valid !== 1'b0 || ext_data_i_ready !== 1'b0 || ext_busy_o !== 1'b0)
            $display("FAIL rst_mid_ctrl: got valid %b ready %b busy %b want 0 0 0",
                     ext_data_o_valid, ext_data_i_ready, ext_busy_o);
        else n_pass++;
        n_checks++;
        if (ext_data_o_bits !== '0 || ext_beats_sent_o !== '0 || ext_done_o !== 1'b0)
            $display("FAIL rst_mid_data: got sent %0d done %b bits_nonzero %b want 0 0 0",
                     ext_beats_sent_o, ext_done_o, |ext_data_o_bits);
        else n_pass++;
        clear_model(0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (done_cnt != 0 || busy_cnt != 0)
            $display("FAIL rst_mid_no_done: got done %0d busy %0d want 0 0", done_cnt, busy_cnt);
        else n_pass++;
        clear_model(2);
        out_mode = 0;
        load_src(3);
        build_expected(2);
        start_job(2);
        wait_done(1, 40);
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (out_q.size() != exp_q.size() || bad != 0)
            $display("FAIL rst_mid_new_data: got %0d beats (%0d wrong) want %0d", out_q.size(), bad, exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || ext_beats_sent_o !== CW'(2))
            $display("FAIL rst_mid_new_done: got done %0d sent %0d want 1 2", done_cnt, ext_beats_sent_o);
        else n_pass++;
        idle_src();
    endtask

    task automatic test_back_to_back();
        int   bad;
        int   k;
        logic started2;
        logic busy_after_restart;
        clear_model(2);
        in_mode  = 1;
        out_mode = 2;
        load_src(8);
        build_expected(5);
        started2 = 1'b0;
        busy_after_restart = 1'b0;
        start_job(2);
        k = 0;
        while (done_cnt < 2 && k < 300) begin
            tick();
            k++;
            if (ext_done_o && !started2) begin
                started2 = 1'b1;
                job_n    = 3;
                n_acc    = 0;
                n_sent   = 0;
                start_job(3);
                busy_after_restart = ext_busy_o;
            end
        end
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (out_q.size() != exp_q.size() || bad != 0)
            $display("FAIL b2b_data: got %0d beats (%0d wrong) want %0d", out_q.size(), bad, exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt != 2) $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt);
        else n_pass++;
        n_checks++;
        if (sent_at_done_q.size() != 2 || sent_at_done_q[0] !== CW'(2) || sent_at_done_q[1] !== CW'(3))
            $display("FAIL b2b_sent_at_done: got %0d entries %0d %0d want 2 3", sent_at_done_q.size(),
                     (sent_at_done_q.size() > 0) ? sent_at_done_q[0] : '0,
                     (sent_at_done_q.size() > 1) ? sent_at_done_q[1] : '0);
        else n_pass++;
        n_checks++;
        if (busy_after_restart !== 1'b1)
            $display("FAIL b2b_start_on_done: got busy %b want 1", busy_after_restart);
        else n_pass++;
        n_checks++;
        if (done_with_busy != 0) $display("FAIL b2b_done_busy_overlap: got %0d want 0", done_with_busy);
        else n_pass++;
        n_checks++;
        if (ready_viol != 0) $display("FAIL b2b_ready_rule: got %0d violations want 0", ready_viol);
        else n_pass++;
        idle_src();
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_n4_full_rate();
        test_n8_toggle();
        test_zero_length();
        test_restart_ignored();
        test_reset_mid_job();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time %0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memset_stream_sequencer.md
# memset_stream_sequencer

Bounded-length stream stage directly downstream of the memset fill datapath. It consumes the datapath's constant-pattern beat stream and forwards exactly N beats per job to the write streamer through a 2-entry buffer. It then closes the job with busy/done status. The fill datapath itself is stateless; this block provides job length, flow control isolation and completion signalling.

## Interface
- DataWidth, 512: beat width in bits; must be a multiple of 8.
- CountWidth, 32: width of the beat-count CSR and internal counters.
- BufDepth, 2: output buffer entries; fixed at 2, with no other value supported.

Ports, name direction width meaning:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ext_data_i_valid  in  1  beat valid from fill datapath.
- ext_data_i_ready  out  1  beat accepted when high with valid.
- ext_data_i_bits  in  DataWidth  fill beat.
- ext_data_o_valid  out  1  beat valid to write streamer.
- ext_data_o_ready  in  1  write streamer ready.
- ext_data_o_bits  out  DataWidth  forwarded beat.
- ext_csr_i_0  in  CountWidth  number of beats N for the next job.
- ext_start_i  in  1  job start pulse.
- ext_busy_o  out  1  job in progress.
- ext_done_o  out  1  one-cycle completion pulse.
- ext_beats_sent_o  out  CountWidth  output handshakes in the current or last job.

## Operation
- States:
  - IDLE: ready for a new job.
  - RUN: accepting input beats.
  - DRAIN: input closed, buffer emptying.
- IDLE, ext_start_i=1, csr≠0:
  - latch N;
  - clear accept counter and ext_beats_sent_o;
  - go to RUN.
- IDLE, ext_start_i=1, csr=0:
  - stay IDLE;
  - ext_done_o pulses the next cycle;
  - ext_beats_sent_o clears to 0.
- ext_start_i while not IDLE: ignored, and the latched N is unchanged.
- ext_data_i_ready = (state==RUN) && accepted<N && buffer not full. It is 0 in IDLE and DRAIN, so stray upstream beats are left unconsumed.
- Input handshake: beat pushed to the buffer, accepted++. When accepted reaches N, go to DRAIN.
- ext_data_o_valid = buffer not empty, and ext_data_o_bits = buffer head. Bits are data-transparent and passed unaltered.
- Output handshake: buffer pops, ext_beats_sent_o++.
- DRAIN→IDLE on the cycle the last output handshake completes, i.e. sent reaches N. ext_done_o is high the following cycle.
- ext_busy_o = (state != IDLE), registered with state.
- Counters are unsigned CountWidth with no wrap. N ≤ 2^CountWidth−1 by construction.

## Timing
- Reset values: all outputs 0, state IDLE, buffer empty, counters 0.
- Reset asserted mid-job: immediate abort, buffered beats discarded, done is not pulsed.
- Start-to-ready: ext_start_i sampled at edge k gives busy=1 and ready eligible from cycle k+1.
- Input-to-output latency is 1 cycle: a beat accepted at edge k is valid on the output after edge k.
- Throughput is 1 beat/cycle with ext_data_o_ready held high. Ready depends only on registered state, so there is no combinational in→out ready path.
- Simultaneous push and pop on a full buffer:
  - not allowed, because ready is 0 when full;
  - push and pop in the same cycle on 1 entry is allowed, and occupancy stays 1.
- Done pulse and busy deassert occur on the same cycle. A new start on that cycle is accepted.

## Structure
- Shared package memset_pkg:
  - state_e typedef {IDLE, RUN, DRAIN};
  - default DataWidth/CountWidth localparams.
- Sub-module memset_skid_fifo: 2-entry register FIFO with push/pop, full/empty and head data. It is instantiated once.
- The top module holds the FSM and the two counters.

## Test plan
- N=4, both sides always ready:
  - beats 0..3 are forwarded in order, one per cycle;
  - busy is high for 5 cycles;
  - done pulses once;
  - beats_sent=4;
  - the 5th upstream beat is not accepted.
- N=8, output ready toggling 1/0:
  - no beat is lost or duplicated;
  - input ready drops while the buffer is full;
  - beats_sent=8 at done.
- N=0 start: busy stays 0, done pulses the next cycle, input ready stays 0.
- Start pulsed again mid-job with csr=100, initial N=3: exactly 3 beats are forwarded, and the job ends on the original count.
- rst_n asserted with 2 beats buffered:
  - outputs go 0 immediately;
  - after release, a new N=2 job forwards only the new beats.
- Back-to-back jobs N=2, then N=3 started on the done cycle:
  - 5 total beats;
  - two done pulses;
  - beats_sent reads 2, then 3.
